alu_pipe: RTL and testbench

//  Parametrised, pipelined successor of the single-cycle datapath ALU. Same 6-bit function encoding
//  (add/sub, compare, logic, shift), but WIDTH-generic, 1- or 2-stage registered, with valid/ready

---
 rtl/alu_pipe_if.sv | 38 +++
 rtl/alu_pipe.sv | 175 +++++++++++++++++
 tb/tb_alu_pipe.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// ============================================================================
// Module   : alu_pipe_if
// Purpose  : Operand/result handshake bundle between the issue logic and alu_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [5:0]       fun;
  logic             sign;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] tag_out;
  logic             ovf_trap;
  logic             ovf_sticky;
  logic             clr_ovf;

  modport master (
    output in_valid, a, b, fun, sign, tag_in, out_ready, clr_ovf,
    input  in_ready, out_valid, result, tag_out, ovf_trap, ovf_sticky
  );

  modport slave (
    input  in_valid, a, b, fun, sign, tag_in, out_ready, clr_ovf,
    output in_ready, out_valid, result, tag_out, ovf_trap, ovf_sticky
  );
endinterface

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module   : alu_pipe
// Purpose  : WIDTH-generic 1/2-stage pipelined ALU with valid/ready flow, tag and overflow trap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  wire logic clk,
  input  wire logic rst_n,
  alu_pipe_if.slave bus
);

  localparam int               c_SHW = $clog2(WIDTH);
  localparam int               c_M   = WIDTH - 1;
  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Everything the final group/compare select needs; this is what stage 1 registers.
  typedef struct packed {
    logic [1:0]       grp;
    logic [2:0]       cmp;
    logic [WIDTH-1:0] sum;
    logic             z;
    logic             n;
    logic             v;
    logic             a_zero;
    logic             a_msb;
    logic [WIDTH-1:0] logic_r;
    logic [WIDTH-1:0] shift_r;
    logic [TAG_W-1:0] tag;
  } payload_t;

  logic [WIDTH-1:0] w_bop;
  logic [WIDTH-1:0] w_sum;
  logic [c_SHW-1:0] w_sh;
  logic             w_v;
  payload_t         w_pl_in;

  logic             w_up_valid;
  payload_t         w_up_pl;
  logic             w_out_free;
  logic             w_out_load;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_tag;
  logic             r_trap;
  logic             r_sticky;

  assign w_bop = bus.fun[0] ? (~bus.b + c_ONE) : bus.b;
  assign w_sum = bus.a + w_bop;
  assign w_sh  = bus.a[c_SHW-1:0];
  assign w_v   = bus.sign
               & (bus.fun[0] ? (bus.a[c_M] != bus.b[c_M]) : (bus.a[c_M] == bus.b[c_M]))
               & (w_sum[c_M] != bus.a[c_M]);

  always_comb begin
    w_pl_in         = '0;
    w_pl_in.grp     = bus.fun[5:4];
    w_pl_in.cmp     = bus.fun[3:1];
    w_pl_in.sum     = w_sum;
    w_pl_in.z       = (w_sum == '0);
    w_pl_in.v       = w_v;
    w_pl_in.n       = bus.sign ? (w_sum[c_M] ^ w_v) : (bus.fun[0] & (bus.b > bus.a));
    w_pl_in.a_zero  = (bus.a == '0);
    w_pl_in.a_msb   = bus.a[c_M];
    w_pl_in.tag     = bus.tag_in;
    case (bus.fun[3:0])
      4'b1000: w_pl_in.logic_r = bus.a & bus.b;
      4'b1110: w_pl_in.logic_r = bus.a | bus.b;
      4'b0110: w_pl_in.logic_r = bus.a ^ bus.b;
      4'b0001: w_pl_in.logic_r = ~(bus.a | bus.b);
      4'b1010: w_pl_in.logic_r = bus.a;
      default: w_pl_in.logic_r = '0;
    endcase
    case (bus.fun[1:0])
      2'b00:   w_pl_in.shift_r = bus.b << w_sh;
      2'b01:   w_pl_in.shift_r = bus.b >> w_sh;
      2'b11:   w_pl_in.shift_r = $signed(bus.b) >>> w_sh;
      default: w_pl_in.shift_r = '0;
    endcase
  end

  function automatic logic [WIDTH-1:0] f_select(input payload_t p);
    logic c;
    case (p.cmp)
      3'b001:  c = p.z;
      3'b000:  c = !p.z;
      3'b010:  c = p.n;
      3'b110:  c = p.a_zero | p.a_msb;
      3'b101:  c = p.a_msb;
      3'b111:  c = !p.a_msb & !p.a_zero;
      default: c = 1'b0;
    endcase
    case (p.grp)
      2'b00:   f_select = p.sum;
      2'b01:   f_select = p.logic_r;
      2'b10:   f_select = p.shift_r;
      default: f_select = {{(WIDTH-1){1'b0}}, c};
    endcase
  endfunction

  assign w_out_free = !r_out_valid | bus.out_ready;
  assign w_out_load = w_up_valid & w_out_free;

  generate
    if (PIPE_STAGES == 1) begin : g_one_stage
      assign w_up_valid   = bus.in_valid;
      assign w_up_pl      = w_pl_in;
      assign bus.in_ready = w_out_free;
    end else begin : g_two_stage
      logic     r_s1_valid;
      payload_t r_s1;
      logic     w_s1_free;

      // Stage 1 can take a new op whenever its current one is leaving this cycle.
      assign w_s1_free    = !r_s1_valid | w_out_free;
      assign bus.in_ready = w_s1_free;
      assign w_up_valid   = r_s1_valid;
      assign w_up_pl      = r_s1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_valid <= 1'b0;
          r_s1       <= '0;
        end else if (bus.in_valid && w_s1_free) begin
          r_s1_valid <= 1'b1;
          r_s1       <= w_pl_in;
        end else if (w_out_free) begin
          r_s1_valid <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_tag       <= '0;
      r_trap      <= 1'b0;
    end else if (w_out_load) begin
      r_out_valid <= 1'b1;
      r_result    <= f_select(w_up_pl);
      r_tag       <= w_up_pl.tag;
      r_trap      <= w_up_pl.v & (w_up_pl.grp == 2'b00);
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // A trap delivered in the same cycle as a clear request takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (r_out_valid && bus.out_ready && r_trap) begin
      r_sticky <= 1'b1;
    end else if (bus.clr_ovf) begin
      r_sticky <= 1'b0;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.result     = r_result;
  assign bus.tag_out    = r_tag;
  assign bus.ovf_trap   = r_trap;
  assign bus.ovf_sticky = r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Self-checking bench for alu_pipe: directed vectors, flow/stall, reset and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe;

  localparam int     c_W  = 32;
  localparam int     c_PS = 2;
  localparam longint c_SMAX = 64'sd2147483647;
  localparam longint c_SMIN = -c_SMAX - 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic        sign;
    logic [31:0] exp_res;
    logic        exp_trap;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        trap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_pipe_if #(.WIDTH(c_W), .TAG_W(5)) bus ();

  alu_pipe #(.WIDTH(c_W), .PIPE_STAGES(c_PS), .TAG_W(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        q[$];
  logic        model_sticky = 1'b0;
  logic        acc = 1'b0;
  logic        got = 1'b0;
  logic [31:0] got_res;
  logic [4:0]  got_tag;
  logic        got_trap;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_res;
  logic [4:0]  prev_tag;
  logic        prev_trap;
  logic        saw_not_ready = 1'b0;
  int          n_out = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: infinite-precision integer arithmetic, then the function table.
  function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic [5:0] fun, input logic sign, input logic [4:0] tag);
    exp_t        e;
    longint      sa, sb, tr;
    logic [31:0] s, r;
    logic        z, v, n, c;
    int          sh;
    sa = sign ? longint'($signed(a)) : longint'(a);
    sb = sign ? longint'($signed(b)) : longint'(b);
    tr = fun[0] ? sa - sb : sa + sb;
    s  = tr[31:0];
    z  = (s == 0);
    v  = sign && (tr > c_SMAX || tr < c_SMIN);
    n  = sign ? (tr < 0) : (fun[0] && (b > a));
    sh = int'(a % 32);
    case (fun[3:1])
      3'b001:  c = z;
      3'b000:  c = !z;
      3'b010:  c = n;
      3'b110:  c = (a == 0) || $signed(a) < 0;
      3'b101:  c = $signed(a) < 0;
      3'b111:  c = $signed(a) > 0;
      default: c = 1'b0;
    endcase
    case (fun[5:4])
      2'b00: r = s;
      2'b01: case (fun[3:0])
               4'b1000: r = a & b;
               4'b1110: r = a | b;
               4'b0110: r = a ^ b;
               4'b0001: r = ~(a | b);
               4'b1010: r = a;
               default: r = 0;
             endcase
      2'b10: case (fun[1:0])
               2'b00:   r = b << sh;
               2'b01:   r = b >> sh;
               2'b11:   r = $signed(b) >>> sh;
               default: r = 0;
             endcase
      default: r = {31'd0, c};
    endcase
    e.res  = r;
    e.tag  = tag;
    e.trap = v && (fun[5:4] == 2'b00);
    return e;
  endfunction

  // One clock: observe and score at negedge, then advance to just past posedge.
  task automatic step();
    exp_t e;
    logic nxt_sticky;
    @(negedge clk);
    if (stall_prev)
      chk("stall_hold", (bus.out_valid && bus.tag_out == prev_tag && bus.ovf_trap == prev_trap)
                        ? bus.result : ~bus.result, prev_res);
    chk("sticky", 32'(bus.ovf_sticky), 32'(model_sticky));
    nxt_sticky = model_sticky;
    got = 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      got = 1'b1; got_res = bus.result; got_tag = bus.tag_out; got_trap = bus.ovf_trap;
      if (q.size() == 0) begin
        chk("unexpected_out", 32'(bus.tag_out), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("sb_result", bus.result, e.res);
        chk("sb_tag", 32'(bus.tag_out), 32'(e.tag));
        chk("sb_trap", 32'(bus.ovf_trap), 32'(e.trap));
        if (e.trap) nxt_sticky = 1'b1;
        else if (bus.clr_ovf) nxt_sticky = 1'b0;
      end
    end else if (bus.clr_ovf) begin
      nxt_sticky = 1'b0;
    end
    model_sticky = nxt_sticky;
    acc = bus.in_valid && bus.in_ready;
    if (acc) q.push_back(ref_model(bus.a, bus.b, bus.fun, bus.sign, bus.tag_in));
    if (!bus.in_ready) saw_not_ready = 1'b1;
    stall_prev = bus.out_valid && !bus.out_ready;
    prev_res = bus.result; prev_tag = bus.tag_out; prev_trap = bus.ovf_trap;
    @(posedge clk);
    #1;
  endtask

  task automatic gen_op();
    bus.a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    bus.b      = ($urandom_range(0, 3) == 0) ? bus.a : $urandom;
    bus.fun    = 6'($urandom_range(0, 63));
    bus.sign   = 1'($urandom_range(0, 1));
    bus.tag_in = 5'($urandom_range(0, 31));
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  vec_t vt[14];
  int   k, sent, cyc, n0;
  logic pending;

  initial begin
    vt[0]  = '{32'd7,         32'd5,         6'b000000, 1'b1, 32'd12,        1'b0};
    vt[1]  = '{32'h8000_0000, 32'd1,         6'b000001, 1'b1, 32'h7FFF_FFFF, 1'b1};
    vt[2]  = '{32'h8000_0000, 32'd1,         6'b000001, 1'b0, 32'h7FFF_FFFF, 1'b0};
    vt[3]  = '{32'hFFFF_FFFF, 32'd1,         6'b110101, 1'b1, 32'd1,         1'b0};
    vt[4]  = '{32'hFFFF_FFFF, 32'd1,         6'b110101, 1'b0, 32'd0,         1'b0};
    vt[5]  = '{32'd9,         32'd9,         6'b110011, 1'b1, 32'd1,         1'b0};
    vt[6]  = '{32'd0,         32'd5,         6'b111111, 1'b1, 32'd0,         1'b0};
    vt[7]  = '{32'd4,         32'hF000_0000, 6'b100011, 1'b1, 32'hFF00_0000, 1'b0};
    vt[8]  = '{32'd4,         32'hF000_0000, 6'b100001, 1'b1, 32'h0F00_0000, 1'b0};
    vt[9]  = '{32'd36,        32'hF000_0000, 6'b100001, 1'b1, 32'h0F00_0000, 1'b0};
    vt[10] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 6'b011000, 1'b0, 32'hF000_F000, 1'b0};
    vt[11] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 6'b010001, 1'b0, 32'h000F_000F, 1'b0};
    vt[12] = '{32'h7FFF_FFFF, 32'd1,         6'b000000, 1'b1, 32'h8000_0000, 1'b1};
    vt[13] = '{32'h8000_0000, 32'd1,         6'b110101, 1'b1, 32'd1,         1'b0};

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.fun = '0; bus.sign = 1'b0;
    bus.tag_in = '0; bus.out_ready = 1'b1; bus.clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_tag", 32'(bus.tag_out), 32'd0);
    chk("rst_trap", 32'(bus.ovf_trap), 32'd0);
    chk("rst_sticky", 32'(bus.ovf_sticky), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors, one op at a time, with latency measurement.
    for (int i = 0; i < 14; i++) begin
      bus.a = vt[i].a; bus.b = vt[i].b; bus.fun = vt[i].fun; bus.sign = vt[i].sign;
      bus.tag_in = 5'(i); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      step();
      chk("vec_accept", 32'(acc), 32'd1);
      bus.in_valid = 1'b0;
      k = 0;
      do begin step(); k++; end while (!got && k < 10);
      chk("vec_latency", 32'(k), 32'(c_PS));
      chk("vec_result", got ? got_res : 32'hDEAD_BEEF, vt[i].exp_res);
      chk("vec_tag", 32'(got_tag), 32'(i));
      chk("vec_trap", 32'(got_trap), 32'(vt[i].exp_trap));
      if (vt[i].exp_trap) chk("vec_sticky_set", 32'(bus.ovf_sticky), 32'd1);
    end

    // Clear sticky, then clear coinciding with a trap handshake.
    bus.clr_ovf = 1'b1; step(); bus.clr_ovf = 1'b0;
    chk("clr_sticky", 32'(bus.ovf_sticky), 32'd0);
    bus.a = 32'h7FFF_FFFF; bus.b = 32'd1; bus.fun = 6'b000000; bus.sign = 1'b1;
    bus.tag_in = 5'd21; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 10) begin step(); k++; end
    chk("trap_arrived", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1; bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    chk("clr_vs_set", 32'(bus.ovf_sticky), 32'd1);
    drain();

    // Full throughput with out_ready held high.
    saw_not_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      gen_op(); bus.in_valid = 1'b1;
      step();
      chk("tput_accept", 32'(acc), 32'd1);
    end
    bus.in_valid = 1'b0;
    chk("tput_inflight", 32'(q.size()), 32'(c_PS));
    drain();

    // Stream with output stalled for cycles 3..5.
    saw_not_ready = 1'b0; n0 = n_out; sent = 0; cyc = 0;
    gen_op(); bus.in_valid = 1'b1;
    while (sent < 8 && cyc < 60) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      step();
      if (acc) begin
        sent++;
        if (sent < 8) gen_op(); else bus.in_valid = 1'b0;
      end
      cyc++;
    end
    chk("stall_sent", 32'(sent), 32'd8);
    chk("stall_backpressure", 32'(saw_not_ready), 32'd1);
    drain();
    chk("stall_count", 32'(n_out - n0), 32'd8);

    // Random traffic against the reference model.
    pending = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!pending) begin
        gen_op();
        bus.in_valid = ($urandom_range(0, 9) < 7);
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.clr_ovf   = ($urandom_range(0, 19) == 0);
      step();
      pending = bus.in_valid && !acc;
    end
    bus.clr_ovf = 1'b0;
    drain();

    // Reset with two ops in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      gen_op(); bus.in_valid = 1'b1; step();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_result", bus.result, 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    q.delete(); stall_prev = 1'b0; model_sticky = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n0 = n_out; bus.out_ready = 1'b1;
    repeat (5) step();
    chk("post_rst_none", 32'(n_out - n0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
